// File: rtl/stage_ex_mc.sv
// Execute stage: single-cycle ALU ops plus a shift-add multiplier,
// with a valid/ready result register on the output.
module stage_ex_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            cmd_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  carry_o,
  output logic                  zero_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic                  busy_o
);

  localparam int W  = DATA_WIDTH;
  localparam int SH = $clog2(W);
  localparam logic [SH-1:0] LAST = SH'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [SH-1:0]   cnt_q, cnt_d;

  logic [W:0]      sum;
  logic [W:0]      diff;
  logic [SH-1:0]   shamt;
  logic [W-1:0]    alu_res;
  logic            alu_c;
  logic [2*W-1:0]  prod;
  logic            in_fire;
  logic            out_fire;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SH-1:0];

  // One partial product per cycle, LSB of the multiplier first
  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign busy_o      = (state_q == MUL);
  assign out_valid_o = (state_q == HOLD);
  assign in_ready_o  = !busy_o && (!out_valid_o || out_ready_i);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  assign res_o   = res_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;
  assign id_o    = id_q;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (cmd_i)
      4'd0: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
      end
      4'd1: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
      end
      4'd2: alu_res = a_i & b_i;
      4'd3: alu_res = a_i | b_i;
      4'd4: alu_res = a_i ^ b_i;
      4'd5: alu_res = a_i << shamt;
      4'd6: alu_res = a_i >> shamt;
      4'd7: alu_res = $signed(a_i) >>> shamt;
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    id_d     = id_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (in_fire) begin
          id_d = id_i;
          if (cmd_i == 4'd8) begin
            state_d  = MUL;
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
          end else begin
            state_d = HOLD;
            res_d   = alu_res;
            carry_d = alu_c;
            zero_d  = (alu_res == '0);
          end
        end else if (out_fire) begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SH'(1);
        if (cnt_q == LAST) begin
          state_d = HOLD;
          res_d   = prod[W-1:0];
          carry_d = |prod[2*W-1:W];
          zero_d  = (prod[W-1:0] == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      id_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stage_ex_mc.sv
// Bench for stage_ex_mc: directed cases with literal results, then
// random traffic checked every cycle against a transaction-level model.
module tb_stage_ex_mc;

  localparam int W  = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cmd;
  logic [W-1:0]  a, b;
  logic [IW-1:0] id;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  res;
  logic          carry, zero, busy;
  logic [IW-1:0] id_out;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  stage_ex_mc #(.DATA_WIDTH(W), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .cmd_i(cmd), .a_i(a), .b_i(b), .id_i(id),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .res_o(res), .carry_o(carry), .zero_o(zero),
    .id_o(id_out), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec arithmetic for one operation
  task automatic model_op(input logic [3:0] c, input logic [W-1:0] x,
                          input logic [W-1:0] y, output logic [W-1:0] r,
                          output logic cy);
    longint unsigned xa, ya, p;
    logic signed [W-1:0] sx;
    int sh;
    xa = longint'(x);
    ya = longint'(y);
    sh = int'(y) % W;
    sx = x;
    r  = '0;
    cy = 1'b0;
    case (c)
      4'd0: begin p = xa + ya; r = p[W-1:0]; cy = (p >= (64'd1 << W)); end
      4'd1: begin p = xa - ya; r = p[W-1:0]; cy = (xa < ya); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << sh;
      4'd6: r = x >> sh;
      4'd7: r = sx >>> sh;
      4'd8: begin p = xa * ya; r = p[W-1:0]; cy = ((p >> W) != 0); end
      default: ;
    endcase
  endtask

  // Transaction-level model: what is held, and how many multiply cycles remain
  logic          m_valid = 0;
  int            m_busy = 0;
  logic [W-1:0]  m_res = '0, p_res = '0;
  logic          m_carry = 0, p_carry = 0;
  logic [IW-1:0] m_id = '0, p_id = '0;

  always @(posedge clk) begin
    logic ready;
    logic [W-1:0] r;
    logic cy;
    if (rst) begin
      started = 1;
      m_valid = 0;
      m_busy  = 0;
    end else begin
      ready = (m_busy == 0) && (!m_valid || out_ready);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1;
          m_res   = p_res;
          m_carry = p_carry;
          m_id    = p_id;
        end
      end else if (ready && in_valid) begin
        model_op(cmd, a, b, r, cy);
        if (cmd == 4'd8) begin
          m_valid = 0;
          m_busy  = W;
          p_res   = r;
          p_carry = cy;
          p_id    = id;
        end else begin
          m_valid = 1;
          m_res   = r;
          m_carry = cy;
          m_id    = id;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy > 0));
      chk("in_ready", 32'(in_ready),
          32'((m_busy == 0) && (!m_valid || out_ready)));
      if (m_valid) begin
        chk("res", 32'(res), 32'(m_res));
        chk("carry", 32'(carry), 32'(m_carry));
        chk("zero", 32'(zero), 32'(m_res == '0));
        chk("id", 32'(id_out), 32'(m_id));
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [IW-1:0] t,
                       input logic ordy);
    @(posedge clk); #1;
    in_valid = 1; cmd = c; a = x; b = y; id = t; out_ready = ordy;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
  endtask

  task automatic mul_run(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [IW-1:0] t, output int n);
    issue(4'd8, x, y, t, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_out_valid", 32'(out_valid), 32'd0);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst = 1; in_valid = 0; cmd = '0; a = '0; b = '0; id = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_flags", 32'({carry, zero}), 32'd0);
    chk("rst_id", 32'(id_out), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    issue(4'd0, 16'hFFFF, 16'h0001, 8'h12, 1'b0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_res", 32'(res), 32'h0000);
    chk("add_cz", 32'({carry, zero}), 32'b11);
    chk("add_id", 32'(id_out), 32'h12);

    issue(4'd1, 16'h0003, 16'h0005, 8'h13, 1'b1);
    chk("sub_res", 32'(res), 32'hFFFE);
    chk("sub_cz", 32'({carry, zero}), 32'b10);

    issue(4'd7, 16'h8000, 16'h0013, 8'h14, 1'b1);
    chk("sra_res", 32'(res), 32'hF000);
    chk("sra_c", 32'(carry), 32'd0);

    mul_run(16'h0123, 16'h0045, 8'h21, n);
    chk("mul1_cycles", 32'(n), 32'd16);
    chk("mul1_valid", 32'(out_valid), 32'd1);
    chk("mul1_res", 32'(res), 32'h4E6F);
    chk("mul1_c", 32'(carry), 32'd0);
    chk("mul1_id", 32'(id_out), 32'h21);

    mul_run(16'h0100, 16'h0100, 8'h22, n);
    chk("mul2_cycles", 32'(n), 32'd16);
    chk("mul2_res", 32'(res), 32'h0000);
    chk("mul2_cz", 32'({carry, zero}), 32'b11);

    issue(4'd9, 16'h1234, 16'h5678, 8'h30, 1'b1);
    chk("undef_res", 32'(res), 32'h0000);
    chk("undef_cz", 32'({carry, zero}), 32'b01);
    chk("undef_id", 32'(id_out), 32'h30);

    // Back-to-back stream
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      in_valid = 1; cmd = 4'd0; a = 16'(k * 3 + 1); b = 16'(k); id = 8'(8'h40 + k);
      @(negedge clk);
      if (k > 0) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_id", 32'(id_out), 32'(8'h40 + k - 1));
      end
    end
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("stream_valid", 32'(out_valid), 32'd1);
    chk("stream_id", 32'(id_out), 32'h43);
    chk("stream_res", 32'(res), 32'd13);

    // Backpressure then release with a same-cycle accept
    issue(4'd4, 16'h5A5A, 16'h0FF0, 8'h77, 1'b0);
    @(posedge clk); #1;
    in_valid = 1; cmd = 4'd3; a = 16'h00F0; b = 16'h0F00; id = 8'h78;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", 32'(res), 32'h55AA);
      chk("hold_id", 32'(id_out), 32'h77);
      chk("hold_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("next_valid", 32'(out_valid), 32'd1);
    chk("next_res", 32'(res), 32'h0FF0);
    chk("next_id", 32'(id_out), 32'h78);

    // Reset in the 7th multiply cycle
    @(posedge clk); #1;
    in_valid = 1; cmd = 4'd8; a = 16'd3; b = 16'd5; id = 8'h99;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    out_ready = 0;
    repeat (20) begin
      @(negedge clk);
      chk("abort_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      cmd       = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      a         = 16'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      id        = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
